// File: rtl/stack_ctrl_if.sv
// stack_ctrl_if: request handshake between decoder/interrupt unit and stack_ctrl
interface stack_ctrl_if #(parameter int DATA_W = 16);
  logic              req_valid;
  logic [2:0]        req_op;
  logic [DATA_W-1:0] req_data;
  logic              req_ready;
  modport master (output req_valid, req_op, req_data, input req_ready);
  modport slave  (input req_valid, req_op, req_data, output req_ready);
endinterface

// File: rtl/stack_ctrl.sv
// stack_ctrl: sequences SP strobes and stack RAM accesses for push/pop/call/ret/int/reti/ldsp
module stack_ctrl #(
  parameter int         DATA_W      = 16,
  parameter logic [9:0] STACK_TOP   = 10'h3FF,
  parameter logic [9:0] STACK_LIMIT = 10'h300,
  parameter logic [9:0] INT_VEC     = 10'h004
) (
  input  logic              clk,
  input  logic              rst,
  stack_ctrl_if.slave       req,
  input  logic [9:0]        pc_in,
  input  logic [DATA_W-1:0] flags_in,
  input  logic [9:0]        sp_in,
  output logic              sp_inc,
  output logic              sp_dec,
  output logic              sp_load,
  output logic [9:0]        sp_din,
  output logic [9:0]        mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pop_data,
  output logic [9:0]        pc_out,
  output logic              pc_load,
  output logic [DATA_W-1:0] flags_out,
  output logic              flags_load,
  output logic              done,
  output logic              fault,
  output logic              fault_sticky
);
  typedef enum logic [2:0] {IDLE, WR_A, WR_B, RD_A, RD_B, RD_C, SPLD, FLT} state_t;
  typedef enum logic [2:0] {PUSH, POP, CALL, RET, INT, RETI, LDSP, NOP} op_t;
  state_t            state;
  op_t               op;
  op_t               rop;
  logic              flt;
  logic [9:0]        pc_reg;
  logic [DATA_W-1:0] flags_reg, flags_lat, pop_reg;
  assign rop = op_t'(req.req_op);
  assign req.req_ready = state == IDLE;
  // a push writes the free word at SP, a pop reads the word just above it
  assign mem_addr = mem_we ? sp_in : sp_in + 10'd1;
  // read results are forwarded straight from the RAM in the cycle they arrive, then held
  assign pop_data  = (state == RD_B && op == POP) ? mem_rdata : pop_reg;
  assign pc_out    = ((state == RD_B && op == RET) || state == RD_C) ? mem_rdata[9:0] : pc_reg;
  assign flags_out = (state == RD_B && op == RETI) ? mem_rdata : flags_reg;
  // range check on the SP seen at accept; INT needs two free words, RETI two filled ones
  assign flt = (rop == PUSH || rop == CALL) ? sp_in < STACK_LIMIT :
               rop == INT                   ? sp_in < STACK_LIMIT + 10'd1 :
               (rop == POP || rop == RET)   ? sp_in > STACK_TOP - 10'd1 :
               rop == RETI                  ? sp_in > STACK_TOP - 10'd2 : 1'b0;
  // sequencer: strobes for each cycle are registered on the edge that enters it
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      op <= NOP;
      sp_inc <= 1'b0;
      sp_dec <= 1'b0;
      sp_load <= 1'b0;
      sp_din <= '0;
      mem_we <= 1'b0;
      mem_re <= 1'b0;
      mem_wdata <= '0;
      pc_load <= 1'b0;
      flags_load <= 1'b0;
      done <= 1'b0;
      fault <= 1'b0;
      fault_sticky <= 1'b0;
      pc_reg <= '0;
      flags_reg <= '0;
      flags_lat <= '0;
      pop_reg <= '0;
    end else begin
      sp_inc <= 1'b0;
      sp_dec <= 1'b0;
      sp_load <= 1'b0;
      mem_we <= 1'b0;
      mem_re <= 1'b0;
      pc_load <= 1'b0;
      flags_load <= 1'b0;
      done <= 1'b0;
      fault <= 1'b0;
      case (state)
        IDLE: if (req.req_valid) begin
          op <= rop;
          flags_lat <= flags_in;
          if (flt) begin
            state <= FLT;
            done <= 1'b1;
            fault <= 1'b1;
            fault_sticky <= 1'b1;
          end else case (rop)
            PUSH, CALL, INT: begin
              state <= WR_A;
              mem_we <= 1'b1;
              sp_dec <= 1'b1;
              mem_wdata <= rop == PUSH ? req.req_data : DATA_W'(pc_in);
              done <= rop != INT;
              pc_load <= rop == CALL;
              if (rop == CALL) pc_reg <= req.req_data[9:0];
            end
            POP, RET, RETI: begin
              state <= RD_A;
              mem_re <= 1'b1;
              sp_inc <= 1'b1;
            end
            default: begin
              state <= SPLD;
              sp_load <= rop == LDSP;
              sp_din <= req.req_data[9:0];
              done <= 1'b1;
            end
          endcase
        end
        WR_A: if (op == INT) begin
          state <= WR_B;
          mem_we <= 1'b1;
          sp_dec <= 1'b1;
          mem_wdata <= flags_lat;
          pc_load <= 1'b1;
          pc_reg <= INT_VEC;
          done <= 1'b1;
        end else state <= IDLE;
        RD_A: begin
          state <= RD_B;
          done <= op != RETI;
          pc_load <= op == RET;
          flags_load <= op == RETI;
          mem_re <= op == RETI;
          sp_inc <= op == RETI;
        end
        RD_B: begin
          state <= op == RETI ? RD_C : IDLE;
          pc_load <= op == RETI;
          done <= op == RETI;
          if (op == POP) pop_reg <= mem_rdata;
          if (op == RET) pc_reg <= mem_rdata[9:0];
          if (op == RETI) flags_reg <= mem_rdata;
        end
        RD_C: begin
          state <= IDLE;
          pc_reg <= mem_rdata[9:0];
        end
        default: state <= IDLE;
      endcase
    end
endmodule
